and_gate_array: RTL and testbench
=================================

Name: and_gate_array

Overview:
- Registered, parameterized AND-gate array for the MAC datapath.
- Produces the bitwise AND of two operands and the full WIDTH x WIDTH partial-product matrix that feeds the adder tree.
- With WIDTH=1 it reduces to a registered 2-input AND gate (truth table 00->0, 01->0, 10->0, 11->1).
- Sits between the operand input registers and the partial-product reduction stage.

Parameters:
- WIDTH, 8, operand width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  registered bitwise AND, y[i] = a[i] & b[i].
- pp  output  WIDTH*WIDTH  registered partial products, pp[i*WIDTH+j] = a[j] & b[i] (row i = b bit i).
- any_one  output  1  registered reduction-OR of y (1 if any AND bit is set).
- out_valid  output  1  y/pp/any_one hold a freshly captured result.

Behaviour:
- Reset: rst_n low forces y, pp, any_one and out_valid to 0 immediately, independent of clk. Reset is released synchronously in effect: the first capture can occur on the first rising edge with rst_n high.
- Latency: exactly 1 cycle. Operands sampled at rising edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1 for that cycle.
- Hold: edge with in_valid=0 leaves y, pp and any_one unchanged and sets out_valid=0. a and b are don't-care (X tolerated, must not propagate).
- Back-to-back: in_valid high on consecutive edges updates every cycle; no stall, no backpressure, no ready signal.
- any_one is computed from the same sampled a&b as y. It is never derived from the previous y, so it is coherent with y in the same cycle.
- Width rules: purely bitwise, no carries or sign handling. All bits are independent. For WIDTH=1, pp == y.
- Reset mid-operation: an in-flight result is discarded and out_valid drops to 0 asynchronously. No result is produced for operands sampled before reset.
- All outputs are driven directly from flops; no combinational path from inputs to outputs.

Decomposition:
- Shared package mac_pkg:
  - MAC_WIDTH default constant (8).
  - pp index helper function pp_idx(row, col) = row*WIDTH+col.
- Sub-module and_cell: a 1-bit AND with enable flop and async active-low reset. Instantiated WIDTH*WIDTH times via generate for pp, and WIDTH times for y.
- any_one and out_valid are flopped in the top level.

Test Plan:
- Truth table, WIDTH=8: (a,b) = (0x00,0x00), (0x00,0xFF), (0xFF,0x00), (0xFF,0xFF), one per cycle with in_valid=1 -> one cycle later y = 0x00, 0x00, 0x00, 0xFF; any_one = 0,0,0,1; out_valid=1 each cycle.
- Partial products: a=0xA5, b=0x03 -> y=0x01. pp rows 0 and 1 = 0xA5, rows 2..7 = 0x00. any_one=1.
- Hold: capture a=0x0F, b=0x3C (y=0x0C), then 3 cycles with in_valid=0 and a/b=X -> y stays 0x0C, pp unchanged, out_valid=0, no X on outputs.
- Async reset mid-stream: while y=0xFF and out_valid=1, pull rst_n low between clock edges -> all outputs 0 before the next edge. After release, a=0x81, b=0x80 -> y=0x80 one cycle after the first valid edge.
- WIDTH=1 instance: drive (0,0), (0,1), (1,0), (1,1) -> y = 0,0,0,1 with 1-cycle latency; pp equals y.
- Random back-to-back: 1000 random a/b with random in_valid -> y, pp and any_one match the reference model every cycle; out_valid equals in_valid delayed by one cycle.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC datapath.
package mac_pkg;

  localparam int unsigned MAC_WIDTH = 8;

  // Flat index of partial product (row = b bit, col = a bit) in a width x width matrix.
  function automatic int unsigned pp_idx(input int unsigned row,
                                         input int unsigned col,
                                         input int unsigned width);
    return row * width + col;
  endfunction

endpackage

// File: rtl/and_cell.sv
// 1-bit registered AND with capture enable and async active-low reset.
module and_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  logic r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= 1'b0;
    end else if (i_en) begin
      r_y <= i_a & i_b;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/and_gate_array.sv
// Registered AND-gate array: bitwise AND plus full partial-product matrix,
// one cycle of latency, outputs held while in_valid is low.
module and_gate_array
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = MAC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         y,
  output logic [WIDTH*WIDTH-1:0]   pp,
  output logic                     any_one,
  output logic                     out_valid
);

  logic [WIDTH-1:0] w_and;
  logic             r_any_one;
  logic             r_out_valid;

  assign w_and = a & b;

  // Partial-product matrix: row i uses b[i], column j uses a[j].
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
      localparam int unsigned IDX = pp_idx(gi, gj, WIDTH);
      and_cell u_pp (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (in_valid),
        .i_a   (a[gj]),
        .i_b   (b[gi]),
        .o_y   (pp[IDX])
      );
    end
  end

  for (genvar gk = 0; gk < WIDTH; gk++) begin : g_y
    and_cell u_y (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (in_valid),
      .i_a   (a[gk]),
      .i_b   (b[gk]),
      .o_y   (y[gk])
    );
  end

  // any_one comes from the sampled operands, so it is coherent with y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any_one   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_any_one <= |w_and;
      end
    end
  end

  assign any_one   = r_any_one;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_and_gate_array.sv
// Directed and random checks of and_gate_array at WIDTH=8 and WIDTH=1.
module tb_and_gate_array;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  y;
  logic [63:0] pp;
  logic        any_one;
  logic        out_valid;

  logic        in_valid1;
  logic [0:0]  a1;
  logic [0:0]  b1;
  logic [0:0]  y1;
  logic [0:0]  pp1;
  logic        any_one1;
  logic        out_valid1;

  int n_cmp = 0;
  int n_err = 0;

  and_gate_array #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .y         (y),
    .pp        (pp),
    .any_one   (any_one),
    .out_valid (out_valid)
  );

  and_gate_array #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .a         (a1),
    .b         (b1),
    .y         (y1),
    .pp        (pp1),
    .any_one   (any_one1),
    .out_valid (out_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Row i of the matrix is a copy of x when m[i] is set, else zero.
  function automatic logic [63:0] pp_model(input logic [7:0] x, input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r[i*8 +: 8] = x;
    end
    return r;
  endfunction

  task automatic step(input logic [7:0] va, input logic [7:0] vb, input logic v);
    a = va;
    b = vb;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic va, input logic vb, input logic exp_y);
    a1 = va;
    b1 = vb;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    chk("w1_y", 64'(y1), 64'(exp_y));
    chk("w1_pp", 64'(pp1), 64'(exp_y));
    chk("w1_ov", 64'(out_valid1), 64'd1);
  endtask

  logic [7:0]  m_y;
  logic [63:0] m_pp;
  logic        m_any;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic        rv;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_valid1 = 1'b0;
    a1        = '0;
    b1        = '0;
    #12;
    chk("rst_y", 64'(y), 64'h0);
    chk("rst_pp", pp, 64'h0);
    chk("rst_any", 64'(any_one), 64'h0);
    chk("rst_ov", 64'(out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Truth table across the full word
    step(8'h00, 8'h00, 1'b1);
    chk("tt0_y", 64'(y), 64'h00); chk("tt0_any", 64'(any_one), 64'd0); chk("tt0_ov", 64'(out_valid), 64'd1);
    step(8'h00, 8'hFF, 1'b1);
    chk("tt1_y", 64'(y), 64'h00); chk("tt1_any", 64'(any_one), 64'd0); chk("tt1_ov", 64'(out_valid), 64'd1);
    step(8'hFF, 8'h00, 1'b1);
    chk("tt2_y", 64'(y), 64'h00); chk("tt2_any", 64'(any_one), 64'd0); chk("tt2_ov", 64'(out_valid), 64'd1);
    step(8'hFF, 8'hFF, 1'b1);
    chk("tt3_y", 64'(y), 64'hFF); chk("tt3_any", 64'(any_one), 64'd1); chk("tt3_ov", 64'(out_valid), 64'd1);
    chk("tt3_pp", pp, 64'hFFFF_FFFF_FFFF_FFFF);

    // Partial products
    step(8'hA5, 8'h03, 1'b1);
    chk("pp_y", 64'(y), 64'h01);
    chk("pp_pp", pp, 64'h0000_0000_0000_A5A5);
    chk("pp_any", 64'(any_one), 64'd1);

    // Hold with X operands
    step(8'h0F, 8'h3C, 1'b1);
    chk("hold_cap_y", 64'(y), 64'h0C);
    chk("hold_cap_pp", pp, 64'h0000_0F0F_0F0F_0000);
    for (int k = 0; k < 3; k++) begin
      step('x, 'x, 1'b0);
      chk("hold_y", 64'(y), 64'h0C);
      chk("hold_pp", pp, 64'h0000_0F0F_0F0F_0000);
      chk("hold_any", 64'(any_one), 64'd1);
      chk("hold_ov", 64'(out_valid), 64'd0);
      chk("hold_noX", 64'($isunknown({y, pp, any_one, out_valid})), 64'd0);
    end

    // Async reset mid-stream
    step(8'hFF, 8'hFF, 1'b1);
    chk("pre_rst_y", 64'(y), 64'hFF);
    chk("pre_rst_ov", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y", 64'(y), 64'h0);
    chk("arst_pp", pp, 64'h0);
    chk("arst_any", 64'(any_one), 64'd0);
    chk("arst_ov", 64'(out_valid), 64'd0);
    a = 8'h11;
    b = 8'h11;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("in_rst_y", 64'(y), 64'h0);
    chk("in_rst_ov", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    step(8'h81, 8'h80, 1'b1);
    chk("post_rst_y", 64'(y), 64'h80);
    chk("post_rst_pp", pp, 64'h8100_0000_0000_0000);
    chk("post_rst_any", 64'(any_one), 64'd1);
    chk("post_rst_ov", 64'(out_valid), 64'd1);
    step(8'h00, 8'h00, 1'b0);

    // WIDTH=1 instance truth table
    step1(1'b0, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0);
    step1(1'b1, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b1);
    chk("w1_any", 64'(any_one1), 64'd1);
    in_valid1 = 1'b0;

    // Random back-to-back against the reference model
    m_y   = 8'h80;
    m_pp  = 64'h8100_0000_0000_0000;
    m_any = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rv = 1'($urandom_range(0, 1));
      step(ra, rb, rv);
      if (rv) begin
        m_y   = ra & rb;
        m_pp  = pp_model(ra, rb);
        m_any = (m_y != 8'h00);
      end
      chk("rnd_y", 64'(y), 64'(m_y));
      chk("rnd_pp", pp, m_pp);
      chk("rnd_any", 64'(any_one), 64'(m_any));
      chk("rnd_ov", 64'(out_valid), 64'(rv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
